// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array sequencer.
// done_latency() gives the start-to-done cycle count for a job of length K.
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      FEED   = 3'd2,
      DRAIN  = 3'd3,
      RESULT = 3'd4
   } state_e;

   localparam int SYS_N  = 4;
   localparam int SYS_KW = 8;
   localparam int SYS_TW = SYS_KW + 1;

   function automatic int unsigned done_latency(input int unsigned k,
                                                input int unsigned n,
                                                input int unsigned pipe_lat);
      if (k == 0) return 2;
      return k + 2 * n - 1 + pipe_lat;
   endfunction

endpackage

// File: rtl/skew_valid_gen.sv
// Per-lane operand-valid mask for a skewed systolic feed.
// Lane r carries element (t - r) while 0 <= t - r < K; the math is done one bit wider than t.
module skew_valid_gen #(
   parameter int N  = 4,
   parameter int KW = 8,
   parameter int TW = KW + 1
) (
   input  logic [TW-1:0] t,
   input  logic [KW-1:0] k_len,
   input  logic          feed,
   output logic [N-1:0]  valid
);

   logic [TW:0] t_ext;
   logic [TW:0] k_ext;
   logic [TW:0] lane;
   logic [TW:0] diff;

   always_comb begin
      t_ext = {1'b0, t};
      k_ext = (TW+1)'(k_len);
      valid = '0;
      lane  = '0;
      diff  = '0;
      for (int r = 0; r < N; r++) begin
         lane     = (TW+1)'(r);
         diff     = t_ext - lane;
         valid[r] = feed && (t_ext >= lane) && (diff < k_ext);
      end
   end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic MAC array: clear, skewed feed, drain, hold.
// Define SYSTOLIC_CTRL_PERF_EN to add the busy-cycle and job counters (o_perf_cyc, o_perf_jobs).
module systolic_ctrl
   import systolic_pkg::*;
#(
   parameter int N        = SYS_N,
   parameter int KW       = SYS_KW,
   parameter int TW       = KW + 1,
   parameter int PIPE_LAT = 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   input  logic [KW-1:0] i_k_len,
   input  logic          i_mode,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_arr_en,
   output logic          o_arr_mode,
   output logic [TW-1:0] o_t,
   output logic [N-1:0]  o_a_valid,
   output logic [N-1:0]  o_b_valid
`ifdef SYSTOLIC_CTRL_PERF_EN
   ,
   output logic [31:0]   o_perf_cyc,
   output logic [15:0]   o_perf_jobs
`endif
);

   // The last FEED cycle already moves the final operands one hop, so DRAIN is
   // one shorter than the N-1+PIPE_LAT cycles they need to reach PE(N-1,N-1).
   localparam int            DRAIN_LEN  = N - 2 + PIPE_LAT;
   localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_LEN - 1);

   state_e        state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [KW-1:0] k_q, k_d;
   logic          mode_q, mode_d;
   logic          done_q, done_d;
   logic          start_acc;
   logic          in_feed;
   logic [TW:0]   feed_last;

   assign feed_last = (TW+1)'(k_q) + (TW+1)'(N - 2);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         k_q     <= '0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      k_d        = k_q;
      mode_d     = mode_q;
      done_d     = 1'b0;
      start_acc  = 1'b0;
      in_feed    = 1'b0;
      o_busy     = 1'b0;
      o_arr_en   = 1'b0;
      o_t        = '0;

      case (state_q)
         IDLE, RESULT: begin
            o_arr_en  = (state_q == RESULT);
            start_acc = i_rst_n && i_start;
            o_busy    = start_acc;
            if (start_acc) begin
               state_d = CLEAR;
               k_d     = i_k_len;
               mode_d  = i_mode;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            o_busy = 1'b1;
            cnt_d  = '0;
            if (k_q == '0) begin
               state_d = RESULT;
               done_d  = 1'b1;
            end else begin
               state_d = FEED;
            end
         end
         FEED: begin
            o_busy   = 1'b1;
            o_arr_en = 1'b1;
            in_feed  = 1'b1;
            o_t      = cnt_q;
            if ({1'b0, cnt_q} == feed_last) begin
               cnt_d = '0;
               if (DRAIN_LEN <= 0) begin
                  state_d = RESULT;
                  done_d  = 1'b1;
               end else begin
                  state_d = DRAIN;
               end
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         DRAIN: begin
            o_busy   = 1'b1;
            o_arr_en = 1'b1;
            if (cnt_q == DRAIN_LAST) begin
               cnt_d   = '0;
               state_d = RESULT;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign o_done     = done_q;
   assign o_arr_mode = mode_q;

   skew_valid_gen #(.N(N), .KW(KW), .TW(TW)) u_a_valid (
      .t     (cnt_q),
      .k_len (k_q),
      .feed  (in_feed),
      .valid (o_a_valid)
   );

   skew_valid_gen #(.N(N), .KW(KW), .TW(TW)) u_b_valid (
      .t     (cnt_q),
      .k_len (k_q),
      .feed  (in_feed),
      .valid (o_b_valid)
   );

`ifdef SYSTOLIC_CTRL_PERF_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_perf_cyc  <= '0;
         o_perf_jobs <= '0;
      end else begin
         if (o_busy && (o_perf_cyc != 32'hFFFF_FFFF)) o_perf_cyc <= o_perf_cyc + 32'd1;
         if (o_done) o_perf_jobs <= o_perf_jobs + 16'd1;
      end
   end
`else
   // No performance counters in this build.
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed self-checking bench for systolic_ctrl (N=4, PIPE_LAT=1).
// Perf counter checks are compiled in only with SYSTOLIC_CTRL_PERF_EN.
module tb_systolic_ctrl;
   import systolic_pkg::*;

   localparam int N        = 4;
   localparam int KW       = 8;
   localparam int TW       = KW + 1;
   localparam int PIPE_LAT = 1;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_start;
   logic [KW-1:0] i_k_len;
   logic          i_mode;
   logic          o_busy;
   logic          o_done;
   logic          o_arr_en;
   logic          o_arr_mode;
   logic [TW-1:0] o_t;
   logic [N-1:0]  o_a_valid;
   logic [N-1:0]  o_b_valid;
`ifdef SYSTOLIC_CTRL_PERF_EN
   logic [31:0]   o_perf_cyc;
   logic [15:0]   o_perf_jobs;
`endif

   int checks   = 0;
   int failures = 0;

   systolic_ctrl #(.N(N), .KW(KW), .TW(TW), .PIPE_LAT(PIPE_LAT)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_start    (i_start),
      .i_k_len    (i_k_len),
      .i_mode     (i_mode),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_arr_en   (o_arr_en),
      .o_arr_mode (o_arr_mode),
      .o_t        (o_t),
      .o_a_valid  (o_a_valid),
      .o_b_valid  (o_b_valid)
`ifdef SYSTOLIC_CTRL_PERF_EN
      ,
      .o_perf_cyc (o_perf_cyc),
      .o_perf_jobs(o_perf_jobs)
`endif
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  o_busy,     0);
      check({tag, "_done"},  o_done,     0);
      check({tag, "_en"},    o_arr_en,   0);
      check({tag, "_mode"},  o_arr_mode, 0);
      check({tag, "_t"},     o_t,        0);
      check({tag, "_av"},    o_a_valid,  0);
      check({tag, "_bv"},    o_b_valid,  0);
   endtask

   // Issues a start, then waits (bounded) for o_done; leaves the bench in the done cycle.
   task automatic run_job(input string tag, input int k, input logic mode, input int exp_lat);
      int n;
      int budget;
      budget    = int'(done_latency(k, N, PIPE_LAT)) + 8;
      i_k_len   = k[KW-1:0];
      i_mode    = mode;
      i_start   = 1'b1;
      #1;
      tick();
      i_start = 1'b0;
      n = 1;
      while (o_done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_done_seen"}, o_done, 1);
      check({tag, "_lat"}, n, exp_lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] av [7];
      int n;
      int extra;
      av = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

      i_rst_n = 1'b0;
      i_start = 1'b0;
      i_k_len = '0;
      i_mode  = 1'b0;
      #12;
      check_all_zero("rst");
      tick();
      i_rst_n = 1'b1;
      tick();
      check("idle_en", o_arr_en, 0);
      check("idle_busy", o_busy, 0);

      // K=4 job: exact cycle-by-cycle schedule
      i_k_len = 8'd4;
      i_mode  = 1'b1;
      i_start = 1'b1;
      #1;
      check("k4_busy_start", o_busy, 1);
      tick();
      i_start = 1'b0;
      i_mode  = 1'b0;
      i_k_len = '0;
      check("k4_clear_en", o_arr_en, 0);
      check("k4_clear_busy", o_busy, 1);
      check("k4_clear_mode", o_arr_mode, 1);
      check("k4_clear_av", o_a_valid, 0);
      for (int i = 0; i < 7; i++) begin
         tick();
         check($sformatf("k4_feed%0d_av", i), o_a_valid, av[i]);
         check($sformatf("k4_feed%0d_bv", i), o_b_valid, av[i]);
         check($sformatf("k4_feed%0d_t", i), o_t, i);
         check($sformatf("k4_feed%0d_en", i), o_arr_en, 1);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("k4_drain%0d_av", i), o_a_valid, 0);
         check($sformatf("k4_drain%0d_done", i), o_done, 0);
         check($sformatf("k4_drain%0d_busy", i), o_busy, 1);
         check($sformatf("k4_drain%0d_t", i), o_t, 0);
      end
      tick();
      check("k4_done", o_done, 1);
      check("k4_done_busy", o_busy, 0);
      check("k4_done_en", o_arr_en, 1);

      // Back-to-back: start K=1 in the done cycle
      i_k_len = 8'd1;
      i_mode  = 1'b0;
      i_start = 1'b1;
      #1;
      check("b2b_busy_start", o_busy, 1);
      tick();
      i_start = 1'b0;
      check("b2b_clear_en", o_arr_en, 0);
      check("b2b_clear_mode", o_arr_mode, 0);
      check("b2b_clear_done", o_done, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("b2b_feed%0d_av", i), o_a_valid, 4'b0001 << i);
         check($sformatf("b2b_feed%0d_t", i), o_t, i);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("b2b_drain%0d_bv", i), o_b_valid, 0);
         check($sformatf("b2b_drain%0d_done", i), o_done, 0);
      end
      tick();
      check("b2b_done", o_done, 1);
      tick();
      check("res_done_low", o_done, 0);
      check("res_busy", o_busy, 0);
      check("res_en", o_arr_en, 1);
      check("res_av", o_a_valid, 0);
      check("res_t", o_t, 0);

      // K=0: one CLEAR cycle then done, no valid lanes
      i_k_len = 8'd0;
      i_mode  = 1'b1;
      i_start = 1'b1;
      #1;
      tick();
      i_start = 1'b0;
      check("k0_clear_en", o_arr_en, 0);
      check("k0_clear_busy", o_busy, 1);
      check("k0_clear_av", o_a_valid, 0);
      tick();
      check("k0_done", o_done, 1);
      check("k0_av", o_a_valid, 0);
      check("k0_bv", o_b_valid, 0);
      check("k0_busy", o_busy, 0);
      check("k0_mode", o_arr_mode, 1);
      tick();
      check("k0_done_low", o_done, 0);

      // Starts during FEED (cycle 3) and DRAIN (cycle 8) must be ignored
      i_k_len = 8'd2;
      i_mode  = 1'b0;
      i_start = 1'b1;
      #1;
      tick();
      i_start = 1'b0;
      n = 1;
      while (o_done !== 1'b1 && n < 40) begin
         if (n == 3 || n == 8) begin
            i_k_len = 8'd7;
            i_mode  = 1'b1;
            i_start = 1'b1;
            #1;
            check($sformatf("ign_busy_c%0d", n), o_busy, 1);
         end
         tick();
         i_start = 1'b0;
         n++;
         check($sformatf("ign_mode_c%0d", n), o_arr_mode, 0);
      end
      check("ign_done_seen", o_done, 1);
      check("ign_lat", n, 10);
      extra = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (o_done === 1'b1) extra++;
      end
      check("ign_single_done", extra, 0);

      // Reset asserted mid-FEED at t=3
      i_k_len = 8'd4;
      i_mode  = 1'b1;
      i_start = 1'b1;
      #1;
      tick();
      i_start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("mid_t", o_t, 3);
      check("mid_av", o_a_valid, 4'b1111);
      i_rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
`ifdef SYSTOLIC_CTRL_PERF_EN
      check("perf_rst_cyc", o_perf_cyc, 0);
      check("perf_rst_jobs", o_perf_jobs, 0);
`endif
      tick();
      tick();
      i_rst_n = 1'b1;
      tick();
      check("post_rst_busy", o_busy, 0);
      check("post_rst_en", o_arr_en, 0);
      check("post_rst_t", o_t, 0);

      // Two normal K=4 jobs after reset
      run_job("post_a", 4, 1'b1, 12);
      check("post_a_mode", o_arr_mode, 1);
      tick();
      tick();
      run_job("post_b", 4, 1'b0, 12);
      check("post_b_mode", o_arr_mode, 0);
      tick();
`ifdef SYSTOLIC_CTRL_PERF_EN
      check("perf_jobs", o_perf_jobs, 2);
      check("perf_cyc", o_perf_cyc, 24);
`endif
      check("final_busy", o_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
